uart_butterfly_loader: RTL and testbench

//  UART receive side of the butterfly link. Deserialises 8N1 bytes from the host and packs 12 bytes into the

---
 rtl/uart_butterfly_loader_pkg.sv | 22 ++
 rtl/uart_butterfly_loader_rx.sv | 102 ++++++++++
 rtl/uart_butterfly_loader.sv | 116 +++++++++++
 tb/tb_uart_butterfly_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_butterfly_loader_pkg.sv
// Shared constants and RX state encoding for the butterfly UART loader.
package uart_butterfly_loader_pkg;

  localparam int BYTES_PER_FRAME = 12;
  localparam int OPERANDS        = 6;

  // Staging / output word order; matches the TX result stream order.
  localparam int OP_IN0_RE = 0;
  localparam int OP_IN0_IM = 1;
  localparam int OP_IN1_RE = 2;
  localparam int OP_IN1_IM = 3;
  localparam int OP_TW_RE  = 4;
  localparam int OP_TW_IM  = 5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_butterfly_loader_rx.sv
// 8N1 UART receiver: input synchroniser plus mid-bit sampling FSM.
// Counterpart of UART_TX; reports a byte, a framing error, or activity.
module uart_rx
  import uart_butterfly_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_RX_bit,
  output logic [7:0] o_RX_byte,
  output logic       o_RX_dv,
  output logic       o_RX_ferr,
  output logic       o_RX_active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_RX_bit;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM: start-bit qualification at half a bit, then one sample per bit time.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      o_RX_byte <= '0;
      o_RX_dv   <= 1'b0;
      o_RX_ferr <= 1'b0;
    end else begin
      o_RX_dv   <= 1'b0;
      o_RX_ferr <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              o_RX_dv   <= 1'b1;
              o_RX_byte <= shreg;
            end else begin
              o_RX_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // A byte counts as in flight only once its start bit has been qualified,
  // so a rejected glitch never shows up as activity.
  assign o_RX_active = (state == RX_DATA) || (state == RX_STOP);

endmodule

// File: rtl/uart_butterfly_loader.sv
// Packs 12 received UART bytes into six butterfly operands and strobes a start pulse per frame.
module uart_butterfly_loader
  import uart_butterfly_loader_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_RX_bit,
  output logic [WORD_SIZE-1:0] o_in0_re,
  output logic [WORD_SIZE-1:0] o_in0_im,
  output logic [WORD_SIZE-1:0] o_in1_re,
  output logic [WORD_SIZE-1:0] o_in1_im,
  output logic [WORD_SIZE-1:0] o_twiddle_re,
  output logic [WORD_SIZE-1:0] o_twiddle_im,
  output logic                 o_frame_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
  localparam int K_W      = $clog2(BYTES_PER_FRAME);
  localparam logic [K_W-1:0] K_LAST = K_W'(BYTES_PER_FRAME - 1);

  logic [7:0]           rx_byte;
  logic                 rx_dv;
  logic                 rx_ferr;
  logic                 rx_active;
  logic [K_W-1:0]       k;
  logic [TO_W-1:0]      to_cnt;
  logic [2:0]           wsel;
  logic [WORD_SIZE-1:0] stg [OPERANDS];
  logic [WORD_SIZE-1:0] ops [OPERANDS];

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_RX_bit   (i_RX_bit),
    .o_RX_byte  (rx_byte),
    .o_RX_dv    (rx_dv),
    .o_RX_ferr  (rx_ferr),
    .o_RX_active(rx_active)
  );

  assign wsel = k[K_W-1:1];

  // Staging words: even byte index fills the low byte, odd fills the high byte.
  always_ff @(posedge i_clk) begin
    if (rx_dv) begin
      if (k[0]) stg[wsel][15:8] <= rx_byte;
      else      stg[wsel][7:0]  <= rx_byte;
    end
  end

  // Byte index, inactivity timeout and the two event pulses.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      k             <= '0;
      to_cnt        <= '0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      if (rx_dv) begin
        to_cnt <= '0;
        if (k == K_LAST) begin
          k             <= '0;
          o_frame_valid <= 1'b1;
        end else begin
          k <= k + K_W'(1);
        end
      end else if (rx_ferr) begin
        k           <= '0;
        to_cnt      <= '0;
        o_frame_err <= 1'b1;
      end else if (k == '0) begin
        to_cnt <= '0;
      end else if (!rx_active) begin
        // Timeout wins over a simultaneous start edge; that byte then becomes byte 0.
        if (to_cnt == TO_LAST) begin
          k           <= '0;
          to_cnt      <= '0;
          o_frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

  // Output operands update together on the last byte so they hold still for the whole butterfly run.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < OPERANDS; i++) ops[i] <= '0;
    end else if (rx_dv && (k == K_LAST)) begin
      for (int i = 0; i < OPERANDS - 1; i++) ops[i] <= stg[i];
      ops[OP_TW_IM] <= {rx_byte, stg[OP_TW_IM][7:0]};
    end
  end

  assign o_in0_re     = ops[OP_IN0_RE];
  assign o_in0_im     = ops[OP_IN0_IM];
  assign o_in1_re     = ops[OP_IN1_RE];
  assign o_in1_im     = ops[OP_IN1_IM];
  assign o_twiddle_re = ops[OP_TW_RE];
  assign o_twiddle_im = ops[OP_TW_IM];
  assign o_busy       = (k != '0) || rx_active;

endmodule

// File: tb/tb_uart_butterfly_loader.sv
// Randomised bench for the butterfly UART loader with a frame-level reference model.
module tb_uart_butterfly_loader;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] in0_re, in0_im, in1_re, in1_im, tw_re, tw_im;
  logic        frame_valid, frame_err, busy;

  always #5 clk = ~clk;

  uart_butterfly_loader #(
    .WORD_SIZE   (16),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_RX_bit     (rx),
    .o_in0_re     (in0_re),
    .o_in0_im     (in0_im),
    .o_in1_re     (in1_re),
    .o_in1_im     (in1_im),
    .o_twiddle_re (tw_re),
    .o_twiddle_im (tw_im),
    .o_frame_valid(frame_valid),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int vld_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (frame_valid) vld_cnt++;
    if (frame_err)   err_cnt++;
    if (busy)        busy_cnt++;
  end

  // Reference model: operands as last completed frame, built from 12 bytes, low byte first.
  logic [15:0] model_ops [6];
  logic [7:0]  fb [12];
  int vb, eb, bb;

  task automatic model_load();
    for (int i = 0; i < 6; i++) model_ops[i] = {fb[2*i+1], fb[2*i]};
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) model_ops[i] = 16'h0000;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < 12; i++) begin
      send_byte(fb[i], 1'b1);
      if (gap_max > 0 && i < 11) wait_clks($urandom_range(0, gap_max));
    end
  endtask

  task automatic rand_fb();
    for (int i = 0; i < 12; i++) fb[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_in0_re"}, in0_re, model_ops[0]);
    chk({tag, "_in0_im"}, in0_im, model_ops[1]);
    chk({tag, "_in1_re"}, in1_re, model_ops[2]);
    chk({tag, "_in1_im"}, in1_im, model_ops[3]);
    chk({tag, "_tw_re"},  tw_re,  model_ops[4]);
    chk({tag, "_tw_im"},  tw_im,  model_ops[5]);
  endtask

  task automatic check_events(input string tag, input int ev, input int ee);
    chk({tag, "_nvalid"}, 64'(vld_cnt - vb), 64'(ev));
    chk({tag, "_nerr"},   64'(err_cnt - eb), 64'(ee));
  endtask

  task automatic mark();
    vb = vld_cnt;
    eb = err_cnt;
    bb = busy_cnt;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clks(3);
    check_outs("reset");
    chk("reset_valid", frame_valid, 1'b0);
    chk("reset_err",   frame_err,   1'b0);
    chk("reset_busy",  busy,        1'b0);
    rst_n = 1'b1;
    wait_clks(5);

    // 1: reference frame from the link description
    fb = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00};
    mark();
    send_frame(0);
    wait_clks(40);
    model_load();
    check_events("t1", 1, 0);
    check_outs("t1");
    chk("t1_in0_re_abs", in0_re, 16'h0200);
    chk("t1_in1_im_abs", in1_im, 16'hFF00);
    chk("t1_busy_after", busy, 1'b0);

    // 2: short low glitch is rejected, then the same frame loads again
    mark();
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(60);
    chk("t2_glitch_busy", 64'(busy_cnt - bb), 64'd0);
    check_events("t2_glitch", 0, 0);
    mark();
    send_frame(0);
    wait_clks(40);
    check_events("t2", 1, 0);
    check_outs("t2");

    // 3: bad stop bit on byte 5 drops the frame; then an all-0x11 frame
    rand_fb();
    mark();
    for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b1);
    send_byte(fb[5], 1'b0);
    wait_clks(48);
    check_events("t3_ferr", 0, 1);
    check_outs("t3_hold");
    chk("t3_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) fb[i] = 8'h11;
    mark();
    send_frame(0);
    wait_clks(40);
    model_load();
    check_events("t3", 1, 0);
    check_outs("t3");
    chk("t3_tw_im_abs", tw_im, 16'h1111);

    // 4: three bytes then silence -> timeout, then a realigned frame
    rand_fb();
    mark();
    for (int i = 0; i < 3; i++) send_byte(fb[i], 1'b1);
    wait_clks(4);
    chk("t4_busy_partial", busy, 1'b1);
    wait_clks(TOB * CPB + 20);
    check_events("t4_timeout", 0, 1);
    chk("t4_busy_after", busy, 1'b0);
    check_outs("t4_hold");
    rand_fb();
    mark();
    send_frame(0);
    wait_clks(40);
    model_load();
    check_events("t4", 1, 0);
    check_outs("t4");

    // 5: two frames with a one-bit idle gap between them
    for (int i = 0; i < 12; i++) fb[i] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
    mark();
    send_frame(0);
    wait_clks(CPB);
    for (int i = 0; i < 12; i++) fb[i] = 8'(i + 1);
    send_frame(0);
    wait_clks(40);
    model_load();
    check_events("t5", 2, 0);
    check_outs("t5");
    chk("t5_in0_re_abs", in0_re, 16'h0201);
    chk("t5_tw_im_abs",  tw_im,  16'h0C0B);

    // 6: reset in the middle of byte 7 clears outputs immediately
    rand_fb();
    for (int i = 0; i < 7; i++) send_byte(fb[i], 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(fb[7][i]);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outs("t6_rst");
    chk("t6_rst_busy", busy, 1'b0);
    wait_clks(3);
    rx = 1'b1;
    rst_n = 1'b1;
    wait_clks(40);
    rand_fb();
    mark();
    send_frame(0);
    wait_clks(40);
    model_load();
    check_events("t6", 1, 0);
    check_outs("t6");

    // Random frames with random inter-byte gaps well inside the timeout
    for (int f = 0; f < 4; f++) begin
      rand_fb();
      mark();
      send_frame(40);
      wait_clks($urandom_range(CPB, 4 * CPB));
      model_load();
      check_events($sformatf("rnd%0d", f), 1, 0);
      check_outs($sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
